fetch_sequencer: RTL and testbench

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

---
 rtl/fetch_sequencer.sv | 163 ++++++++++++++++
 tb/tb_fetch_sequencer.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: one outstanding imem request, decode handoff and EX redirects.
// Optional perf counters are enabled with FETCH_SEQ_PERF_EN.
module fetch_sequencer (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_pc,
  input  logic        i_br_taken,
  input  logic [31:0] i_br_target,
  input  logic        i_hz_stall,
  input  logic        i_dec_ready,
  input  logic        i_imem_gnt,
  input  logic        i_imem_rvalid,
  input  logic [31:0] i_imem_rdata,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  output logic [31:0] o_instr,
  output logic [31:0] o_instr_pc,
  output logic        o_instr_valid,
  output logic        o_stall_f,
  output logic        o_br_sel,
  output logic [31:0] o_pc_bru,
  output logic        o_flush_d
`ifdef FETCH_SEQ_PERF_EN
  ,
  output logic [31:0] o_stall_cnt,
  output logic [31:0] o_redir_cnt
`endif
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_HOLD = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] instr_q, instr_d;
  logic        squash_q, squash_d;
  logic        redir_s;
  logic        hand_s;

  // A redirect seen while reset is held must not leak onto the PC controls.
  assign redir_s = i_br_taken & i_rst;
  assign hand_s  = i_dec_ready & ~i_hz_stall;

  // Next-state and output decode; redirect overrides everything else.
  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    instr_d       = instr_q;
    squash_d      = squash_q;
    o_imem_req    = 1'b0;
    o_imem_addr   = 32'd0;
    o_instr       = instr_q;
    o_instr_pc    = fetch_pc_q;
    o_instr_valid = 1'b0;
    o_stall_f     = 1'b1;
    o_br_sel      = 1'b0;
    o_pc_bru      = 32'd0;
    o_flush_d     = 1'b0;
    case (state_q)
      ST_IDLE: state_d = ST_REQ;
      ST_REQ: begin
        // Request is withheld on a redirect so no stale grant can be issued.
        if (redir_s) begin
          state_d = ST_REQ;
        end else begin
          o_imem_req  = 1'b1;
          o_imem_addr = i_pc;
          if (i_imem_gnt) begin
            fetch_pc_d = i_pc;
            state_d    = ST_WAIT;
          end else begin
            state_d = ST_REQ;
          end
        end
      end
      ST_WAIT: begin
        if (i_imem_rvalid) begin
          if (squash_q || redir_s) begin
            squash_d = 1'b0;
            state_d  = ST_REQ;
          end else begin
            instr_d = i_imem_rdata;
            if (hand_s) begin
              o_instr       = i_imem_rdata;
              o_instr_valid = 1'b1;
              o_stall_f     = 1'b0;
              state_d       = ST_REQ;
            end else begin
              state_d = ST_HOLD;
            end
          end
        end else if (redir_s) begin
          squash_d = 1'b1;
        end else begin
          squash_d = squash_q;
        end
      end
      ST_HOLD: begin
        if (redir_s) begin
          state_d = ST_REQ;
        end else begin
          o_instr_valid = 1'b1;
          if (hand_s) begin
            o_stall_f = 1'b0;
            state_d   = ST_REQ;
          end else begin
            state_d = ST_HOLD;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (redir_s) begin
      o_br_sel  = 1'b1;
      o_stall_f = 1'b0;
      o_pc_bru  = i_br_target;
      o_flush_d = 1'b1;
    end else begin
      o_br_sel = 1'b0;
    end
  end

  // State, fetch PC, held word and squash flag registers.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q    <= ST_IDLE;
      fetch_pc_q <= 32'd0;
      instr_q    <= 32'd0;
      squash_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      instr_q    <= instr_d;
      squash_q   <= squash_d;
    end
  end

`ifdef FETCH_SEQ_PERF_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] redir_cnt_q;

  // Free-running wrap-around performance counters.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      stall_cnt_q <= 32'd0;
      redir_cnt_q <= 32'd0;
    end else begin
      if (o_stall_f && (state_q != ST_IDLE)) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
      if (redir_s) begin
        redir_cnt_q <= redir_cnt_q + 32'd1;
      end
    end
  end

  assign o_stall_cnt = stall_cnt_q;
  assign o_redir_cnt = redir_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed scenarios plus randomized traffic
// against a transaction-level model (outstanding request, held-instruction queue, PC register).
module tb_fetch_sequencer;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic [31:0] i_pc;
  logic        i_br_taken;
  logic [31:0] i_br_target;
  logic        i_hz_stall;
  logic        i_dec_ready;
  logic        i_imem_gnt;
  logic        i_imem_rvalid;
  logic [31:0] i_imem_rdata;
  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic [31:0] o_instr;
  logic [31:0] o_instr_pc;
  logic        o_instr_valid;
  logic        o_stall_f;
  logic        o_br_sel;
  logic [31:0] o_pc_bru;
  logic        o_flush_d;
`ifdef FETCH_SEQ_PERF_EN
  logic [31:0] o_stall_cnt;
  logic [31:0] o_redir_cnt;
`endif

  fetch_sequencer dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_pc(i_pc), .i_br_taken(i_br_taken),
    .i_br_target(i_br_target), .i_hz_stall(i_hz_stall), .i_dec_ready(i_dec_ready),
    .i_imem_gnt(i_imem_gnt), .i_imem_rvalid(i_imem_rvalid), .i_imem_rdata(i_imem_rdata),
    .o_imem_req(o_imem_req), .o_imem_addr(o_imem_addr), .o_instr(o_instr),
    .o_instr_pc(o_instr_pc), .o_instr_valid(o_instr_valid), .o_stall_f(o_stall_f),
    .o_br_sel(o_br_sel), .o_pc_bru(o_pc_bru), .o_flush_d(o_flush_d)
`ifdef FETCH_SEQ_PERF_EN
    , .o_stall_cnt(o_stall_cnt), .o_redir_cnt(o_redir_cnt)
`endif
  );

  always #5 i_clk = ~i_clk;

  int total = 0;
  int bad   = 0;

  // Reference model: abstract fetch bookkeeping, not a state machine.
  bit          m_started;
  bit          m_out;
  bit          m_sq;
  logic [31:0] m_opc;
  logic [63:0] m_held[$];
  logic [31:0] pc_r;
  logic [31:0] m_stall_cnt;
  logic [31:0] m_redir_cnt;
  logic        e_stall;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Apply one cycle of inputs and compare DUT outputs against the model.
  task automatic apply(input logic gnt, input logic rv, input logic [31:0] rdata,
                       input logic hz, input logic dr, input logic br, input logic [31:0] tgt);
    logic        e_req, e_valid, hand;
    logic [31:0] e_word, e_ipc;
    i_imem_gnt = gnt; i_imem_rvalid = rv; i_imem_rdata = rdata;
    i_hz_stall = hz; i_dec_ready = dr; i_br_taken = br; i_br_target = tgt;
    i_pc = pc_r;
    #1;
    hand = dr & ~hz;
    e_word = 32'd0; e_ipc = 32'd0;
    if (!m_started) begin
      e_req = 1'b0; e_valid = 1'b0;
    end else begin
      e_req = !m_out && (m_held.size() == 0);
      if (m_held.size() > 0) begin
        e_valid = 1'b1; e_word = m_held[0][31:0]; e_ipc = m_held[0][63:32];
      end else if (m_out && rv && !m_sq) begin
        e_valid = hand; e_word = rdata; e_ipc = m_opc;
      end else begin
        e_valid = 1'b0;
      end
      if (br) e_valid = 1'b0;
    end
    e_stall = !(br || (e_valid && hand));
    if (!br) begin
      check_val("imem_req", o_imem_req, e_req);
      check_val("imem_addr", o_imem_addr, e_req ? pc_r : 32'd0);
    end
    check_val("instr_valid", o_instr_valid, e_valid);
    if (e_valid) begin
      check_val("instr", o_instr, e_word);
      check_val("instr_pc", o_instr_pc, e_ipc);
    end
    check_val("stall_f", o_stall_f, e_stall);
    check_val("br_sel", o_br_sel, br);
    check_val("pc_bru", o_pc_bru, br ? tgt : 32'd0);
    check_val("flush_d", o_flush_d, br);
  endtask

  // Update the model across the rising edge, then return at the next falling edge.
  task automatic advance();
    logic hand;
    hand = i_dec_ready & ~i_hz_stall;
    if (m_started && e_stall) m_stall_cnt = m_stall_cnt + 32'd1;
    if (i_br_taken) begin
      m_redir_cnt = m_redir_cnt + 32'd1;
      m_held.delete();
      if (m_out) begin
        if (i_imem_rvalid) begin m_out = 1'b0; m_sq = 1'b0; end
        else m_sq = 1'b1;
      end
    end else if (m_held.size() > 0) begin
      if (hand) void'(m_held.pop_front());
    end else if (m_out) begin
      if (i_imem_rvalid) begin
        m_out = 1'b0;
        if (!m_sq && !hand) m_held.push_back({m_opc, i_imem_rdata});
        m_sq = 1'b0;
      end
    end else if (m_started && i_imem_gnt) begin
      m_out = 1'b1; m_opc = pc_r;
    end
    m_started = 1'b1;
    if (i_br_taken) pc_r = i_br_target;
    else if (!e_stall) pc_r = pc_r + 32'd4;
    @(posedge i_clk);
    @(negedge i_clk);
  endtask

  // Assert reset for one edge with hostile inputs, check reset values, release.
  task automatic do_reset();
    i_rst = 1'b0; i_br_taken = 1'b1; i_br_target = 32'h55; i_imem_rvalid = 1'b1;
    i_imem_gnt = 1'b1; i_imem_rdata = 32'hFFFF_FFFF; i_dec_ready = 1'b1; i_hz_stall = 1'b0;
    i_pc = 32'h40;
    #1;
    check_val("rst_req", o_imem_req, 32'd0);
    check_val("rst_addr", o_imem_addr, 32'd0);
    check_val("rst_instr", o_instr, 32'd0);
    check_val("rst_ipc", o_instr_pc, 32'd0);
    check_val("rst_valid", o_instr_valid, 32'd0);
    check_val("rst_stall", o_stall_f, 32'd1);
    check_val("rst_br_sel", o_br_sel, 32'd0);
    check_val("rst_pc_bru", o_pc_bru, 32'd0);
    check_val("rst_flush", o_flush_d, 32'd0);
    m_started = 1'b0; m_out = 1'b0; m_sq = 1'b0; m_held.delete();
    pc_r = 32'd0; m_stall_cnt = 32'd0; m_redir_cnt = 32'd0;
    @(posedge i_clk);
    @(negedge i_clk);
    i_rst = 1'b1; i_br_taken = 1'b0; i_imem_rvalid = 1'b0; i_imem_gnt = 1'b0;
  endtask

  initial begin
    i_rst = 1'b1; i_pc = 32'd0; i_br_taken = 1'b0; i_br_target = 32'd0; i_hz_stall = 1'b0;
    i_dec_ready = 1'b0; i_imem_gnt = 1'b0; i_imem_rvalid = 1'b0; i_imem_rdata = 32'd0;
    m_opc = 32'd0; e_stall = 1'b1;
    @(negedge i_clk);
    do_reset();

    // First fetch: IDLE, granted request at PC 0, response handed straight to decode.
    apply(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 32'd0); advance();
    apply(1'b1, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 32'd0); advance();
    apply(1'b0, 1'b1, 32'h0000_0013, 1'b0, 1'b1, 1'b0, 32'd0);
    check_val("first_valid", o_instr_valid, 32'd1);
    check_val("first_instr", o_instr, 32'h0000_0013);
    check_val("first_pc", o_instr_pc, 32'd0);
    check_val("first_stall", o_stall_f, 32'd0);
    advance();

    // Grant delayed three cycles: request and address held steady.
    for (int k = 0; k < 3; k++) begin
      apply(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 32'd0);
      check_val("gnt_wait_req", o_imem_req, 32'd1);
      check_val("gnt_wait_addr", o_imem_addr, 32'd4);
      check_val("gnt_wait_stall", o_stall_f, 32'd1);
      advance();
    end
    apply(1'b1, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 32'd0); advance();

    // Redirect while waiting: stale response dropped, refetch from target.
    apply(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b1, 32'h0000_0100);
    check_val("redir_pc_bru", o_pc_bru, 32'h0000_0100);
    advance();
    apply(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b1, 1'b0, 32'd0);
    check_val("stale_valid", o_instr_valid, 32'd0);
    advance();
    apply(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 32'd0);
    check_val("redir_addr", o_imem_addr, 32'h0000_0100);
    advance();
    apply(1'b1, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 32'd0); advance();

    // Response under hazard stall: held for two cycles, released when the stall drops.
    apply(1'b0, 1'b1, 32'h0000_0ABC, 1'b1, 1'b1, 1'b0, 32'd0); advance();
    for (int k = 0; k < 2; k++) begin
      apply(1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 1'b0, 32'd0);
      check_val("hold_instr", o_instr, 32'h0000_0ABC);
      check_val("hold_stall", o_stall_f, 32'd1);
      advance();
    end
    apply(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 32'd0);
    check_val("hold_release", o_stall_f, 32'd0);
    advance();

    // Reset in WAIT, then stray responses must be ignored.
    apply(1'b1, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 32'd0); advance();
    do_reset();
    apply(1'b0, 1'b1, 32'h1234_5678, 1'b0, 1'b1, 1'b0, 32'd0); advance();
    apply(1'b0, 1'b1, 32'h1234_5678, 1'b0, 1'b1, 1'b0, 32'd0);
    check_val("stray_valid", o_instr_valid, 32'd0);
    advance();

`ifdef FETCH_SEQ_PERF_EN
    dut.stall_cnt_q = 32'hFFFF_FFFE;
    dut.redir_cnt_q = 32'hFFFF_FFFF;
    m_stall_cnt = 32'hFFFF_FFFE;
    m_redir_cnt = 32'hFFFF_FFFF;
`endif

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 699) == 0) begin
        do_reset();
      end else begin
        apply($urandom_range(0, 1) == 1, $urandom_range(0, 9) < 4, $urandom,
              $urandom_range(0, 3) == 0, $urandom_range(0, 9) < 7,
              $urandom_range(0, 11) == 0, $urandom & 32'hFFFF_FFFC);
        advance();
      end
    end

`ifdef FETCH_SEQ_PERF_EN
    check_val("stall_cnt", o_stall_cnt, m_stall_cnt);
    check_val("redir_cnt", o_redir_cnt, m_redir_cnt);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
